// File: rtl/panel_loader.sv
`timescale 1ns/1ps
// panel_loader
//   Front-panel sequencer placed directly upstream of Front_Panel. It takes a
//   stream of (address, data) words and writes each one into PDP-8 memory the
//   way an operator would at the console:
//     1. Set the switches.
//     2. Pulse Load-PC, but only when the address is not the next sequential one.
//     3. Set the switches to the data.
//     4. Pulse Deposit.
//   After the word flagged last, it loads START_PC, raises the run switch,
//   waits for the CPU to start and stop, and then reports halted.
//
// Ports
//   clock         system clock
//   resetN        synchronous reset, active-high
//   in_valid      input word valid
//   in_ready      loader can accept a word (IDLE only)
//   in_addr       target memory address
//   in_data       data to deposit
//   in_last       final word of the image
//   sw            switch bank to Front_Panel: [11:0] value, [12] run switch
//   btnl          Load-PC button
//   btnd          Deposit button
//   run_led       Front_Panel led[12], high while the CPU runs
//   busy          sequencer active (not IDLE, not HALTED)
//   loaded_count  words deposited since reset, saturating at 4096
//   halted        program ran and stopped; held until reset
module panel_loader #(
  parameter int          SETUP_CYC = 10,
  parameter int          PULSE_CYC = 10,
  parameter int          GAP_CYC   = 10,
  parameter logic [11:0] START_PC  = 12'o0200
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_addr,
  input  logic [11:0] in_data,
  input  logic        in_last,
  output logic [12:0] sw,
  output logic        btnl,
  output logic        btnd,
  input  logic        run_led,
  output logic        busy,
  output logic [12:0] loaded_count,
  output logic        halted
);

  localparam int TW = 16;

  typedef enum logic [3:0] {
    IDLE, SET_ADDR, PULSE_LOAD, GAP_LOAD, SET_DATA, PULSE_DEP, GAP_DEP,
    SET_START, PULSE_START, GAP_START, RUN_WAIT, RUNNING, HALTED
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [TW-1:0] phase_len;
  logic          phase_done;
  logic [11:0]   addr_reg, data_reg, next_addr_reg;
  logic          last_reg, first_word_reg, in_ready_reg;
  logic [12:0]   count_reg;
  logic          take;

  assign take = in_valid & in_ready_reg & (state_reg == IDLE);

  // Length of the timed phase the current state belongs to; zero for untimed states.
  always_comb begin
    phase_len = '0;
    case (state_reg)
      SET_ADDR, SET_DATA, SET_START:        phase_len = TW'(SETUP_CYC);
      PULSE_LOAD, PULSE_DEP, PULSE_START:   phase_len = TW'(PULSE_CYC);
      GAP_LOAD, GAP_DEP, GAP_START:         phase_len = TW'(GAP_CYC);
      default:                              phase_len = '0;
    endcase
  end

  assign phase_done = (phase_len != '0) && (timer_reg == phase_len - TW'(1));

  always_comb begin
    state_next = state_reg;
    timer_next = '0;
    case (state_reg)
      IDLE: begin
        // Skip Load-PC when the word continues where the last deposit left the PC.
        if (take)
          state_next = (first_word_reg || (in_addr != next_addr_reg)) ? SET_ADDR : SET_DATA;
      end
      SET_ADDR:    if (phase_done) state_next = PULSE_LOAD;
      PULSE_LOAD:  if (phase_done) state_next = GAP_LOAD;
      GAP_LOAD:    if (phase_done) state_next = SET_DATA;
      SET_DATA:    if (phase_done) state_next = PULSE_DEP;
      PULSE_DEP:   if (phase_done) state_next = GAP_DEP;
      GAP_DEP:     if (phase_done) state_next = last_reg ? SET_START : IDLE;
      SET_START:   if (phase_done) state_next = PULSE_START;
      PULSE_START: if (phase_done) state_next = GAP_START;
      GAP_START:   if (phase_done) state_next = RUN_WAIT;
      RUN_WAIT:    if (run_led)    state_next = RUNNING;
      RUNNING:     if (!run_led)   state_next = HALTED;
      HALTED:      state_next = HALTED;
      default:     state_next = IDLE;
    endcase
    // The timer restarts from zero on every phase change.
    if ((phase_len != '0) && !phase_done)
      timer_next = timer_reg + TW'(1);
  end

  always_ff @(posedge clock) begin
    if (resetN) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      in_ready_reg   <= 1'b0;
      first_word_reg <= 1'b1;
      next_addr_reg  <= '0;
      count_reg      <= '0;
      addr_reg       <= '0;
      data_reg       <= '0;
      last_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      // Registered so it stays low through reset and rises one cycle afterwards.
      in_ready_reg <= (state_next == IDLE);
      if (take) begin
        addr_reg <= in_addr;
        data_reg <= in_data;
        last_reg <= in_last;
      end
      if ((state_reg == GAP_DEP) && phase_done) begin
        if (count_reg != 13'd4096)
          count_reg <= count_reg + 13'd1;
        next_addr_reg  <= addr_reg + 12'd1;  // 7777 wraps to 0000
        first_word_reg <= 1'b0;
      end
    end
  end

  // Switches and buttons decode directly from the state register, so a reset
  // clears both buttons on the very next edge.
  always_comb begin
    sw   = '0;
    btnl = 1'b0;
    btnd = 1'b0;
    case (state_reg)
      SET_ADDR, GAP_LOAD:    sw[11:0] = addr_reg;
      PULSE_LOAD: begin
        sw[11:0] = addr_reg;
        btnl     = 1'b1;
      end
      SET_DATA, GAP_DEP:     sw[11:0] = data_reg;
      PULSE_DEP: begin
        sw[11:0] = data_reg;
        btnd     = 1'b1;
      end
      SET_START, GAP_START:  sw[11:0] = START_PC;
      PULSE_START: begin
        sw[11:0] = START_PC;
        btnl     = 1'b1;
      end
      RUN_WAIT, RUNNING:     sw = {1'b1, START_PC};
      default:               sw = '0;
    endcase
  end

  assign in_ready     = in_ready_reg;
  assign busy         = (state_reg != IDLE) && (state_reg != HALTED);
  assign halted       = (state_reg == HALTED);
  assign loaded_count = count_reg;

endmodule
